motion_delta_extractor: RTL and testbench

MOTION_DELTA_EXTRACTOR -- requirements
Module: motion_delta_extractor

---
 rtl/motion_delta_extractor.sv | 175 +++++++++++++++++
 tb/tb_motion_delta_extractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/motion_delta_extractor.sv
// motion_delta_extractor
//   Splits time into fixed windows (EARLY half, LATE half, one EVAL cycle,
//   one EMIT cycle). Cell events are converted to signed offsets from the grid
//   centre and summed per half. The late-minus-early centroid shift gives the
//   motion direction. That direction is reported once per window with a
//   pass/fail quality flag.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ev_valid/ev_ready   event handshake (ready only in EARLY/LATE)
//   ev_x, ev_y          event cell coordinates
//   class_valid         one-cycle strobe during EMIT
//   class_gesture       0 RIGHT, 1 LEFT, 2 UP, 3 DOWN (held between strobes)
//   class_pass          window met event-count and delta thresholds
//   abs_delta_x/_y      saturated delta magnitudes (held between strobes)
//   debug_state         current FSM state
module motion_delta_extractor #(
  parameter int GRID_BITS          = 4,
  parameter int ACC_SUM_BITS       = 18,
  parameter int EVENT_CNT_BITS     = 16,
  parameter int HALF_WINDOW_CYCLES = 50000,
  parameter int MIN_EVENTS         = 16,
  parameter int MIN_DELTA          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic [GRID_BITS-1:0]    ev_x,
  input  logic [GRID_BITS-1:0]    ev_y,
  output logic [1:0]              class_gesture,
  output logic                    class_valid,
  output logic                    class_pass,
  output logic [ACC_SUM_BITS-1:0] abs_delta_x,
  output logic [ACC_SUM_BITS-1:0] abs_delta_y,
  output logic [1:0]              debug_state
);
  localparam int A  = ACC_SUM_BITS;
  localparam int G  = GRID_BITS;
  localparam int TW = $clog2(HALF_WINDOW_CYCLES);

  localparam logic [1:0] ST_EARLY = 2'd0;
  localparam logic [1:0] ST_LATE  = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  localparam logic [1:0] G_RIGHT = 2'd0;
  localparam logic [1:0] G_LEFT  = 2'd1;
  localparam logic [1:0] G_UP    = 2'd2;
  localparam logic [1:0] G_DOWN  = 2'd3;

  localparam logic signed [A-1:0] S_MAX = {1'b0, {(A-1){1'b1}}};
  localparam logic signed [A-1:0] S_MIN = {1'b1, {(A-1){1'b0}}};

  // One guard bit: overflow shows up as guard bit != result sign bit.
  function automatic logic signed [A-1:0] sat_fit(input logic signed [A:0] s);
    if (s[A] != s[A-1]) return s[A] ? S_MIN : S_MAX;
    return s[A-1:0];
  endfunction

  function automatic logic signed [A-1:0] sat_add(input logic signed [A-1:0] a,
                                                  input logic signed [G-1:0] b);
    logic signed [A:0] s;
    s = {a[A-1], a} + {{(A+1-G){b[G-1]}}, b};
    return sat_fit(s);
  endfunction

  // The most-negative value has no positive twin, so it clips to S_MAX.
  function automatic logic [A-1:0] sat_abs(input logic signed [A-1:0] v);
    if (v == S_MIN) return S_MAX;
    return v[A-1] ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]                state;
  logic [TW-1:0]             timer;
  logic signed [A-1:0]       sum_x_early, sum_y_early, sum_x_late, sum_y_late;
  logic [EVENT_CNT_BITS-1:0] event_count;

  logic                ev_acc, timer_done;
  logic signed [G-1:0] ox, oy;
  logic signed [A-1:0] delta_x, delta_y;
  logic [A-1:0]        ax_c, ay_c, dom_c;
  logic                horiz_c, pass_c;
  logic [1:0]          gest_c;

  assign ev_ready    = !rst && (state == ST_EARLY || state == ST_LATE);
  assign ev_acc      = ev_valid && ev_ready;
  assign timer_done  = (timer == TW'(HALF_WINDOW_CYCLES - 1));
  assign class_valid = !rst && (state == ST_EMIT);
  assign debug_state = state;

  // Subtracting 2^(G-1) from an unsigned G-bit value is the same as
  // flipping its MSB and reading it as two's complement.
  assign ox = {~ev_x[G-1], ev_x[G-2:0]};
  assign oy = {~ev_y[G-1], ev_y[G-2:0]};

  // Classification is computed during EVAL and registered on the EVAL->EMIT
  // edge so the held outputs are already valid alongside class_valid.
  always_comb begin
    delta_x = sat_fit({sum_x_late[A-1], sum_x_late} - {sum_x_early[A-1], sum_x_early});
    delta_y = sat_fit({sum_y_late[A-1], sum_y_late} - {sum_y_early[A-1], sum_y_early});
    ax_c    = sat_abs(delta_x);
    ay_c    = sat_abs(delta_y);
    horiz_c = (ax_c > ay_c);
    if (horiz_c) begin
      gest_c = (!delta_x[A-1] && delta_x != '0) ? G_RIGHT : G_LEFT;
      dom_c  = ax_c;
    end else begin
      gest_c = (!delta_y[A-1] && delta_y != '0) ? G_DOWN : G_UP;
      dom_c  = ay_c;
    end
    pass_c = (event_count >= EVENT_CNT_BITS'(MIN_EVENTS)) && (dom_c >= A'(MIN_DELTA));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_EARLY;
      timer         <= '0;
      sum_x_early   <= '0;
      sum_y_early   <= '0;
      sum_x_late    <= '0;
      sum_y_late    <= '0;
      event_count   <= '0;
      class_gesture <= '0;
      class_pass    <= 1'b0;
      abs_delta_x   <= '0;
      abs_delta_y   <= '0;
    end else begin
      if (ev_acc && event_count != '1) event_count <= event_count + 1'b1;
      case (state)
        ST_EARLY: begin
          // Terminal-cycle events still land in the early sums.
          if (ev_acc) begin
            sum_x_early <= sat_add(sum_x_early, ox);
            sum_y_early <= sat_add(sum_y_early, oy);
          end
          if (timer_done) begin
            timer <= '0;
            state <= ST_LATE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_LATE: begin
          if (ev_acc) begin
            sum_x_late <= sat_add(sum_x_late, ox);
            sum_y_late <= sat_add(sum_y_late, oy);
          end
          if (timer_done) begin
            timer <= '0;
            state <= ST_EVAL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_EVAL: begin
          abs_delta_x   <= ax_c;
          abs_delta_y   <= ay_c;
          class_gesture <= gest_c;
          class_pass    <= pass_c;
          state         <= ST_EMIT;
        end
        default: begin
          sum_x_early <= '0;
          sum_y_early <= '0;
          sum_x_late  <= '0;
          sum_y_late  <= '0;
          event_count <= '0;
          timer       <= '0;
          state       <= ST_EARLY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_motion_delta_extractor.sv
module tb_motion_delta_extractor;
  localparam int H0 = 8;
  localparam int A0 = 18;
  localparam int H1 = 24;
  localparam int A1 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ev_valid0, ev_valid1, ev_ready0, ev_ready1;
  logic [3:0]    ev_x0, ev_y0, ev_x1, ev_y1;
  logic [1:0]    gest0, gest1, dbg0, dbg1;
  logic          cv0, cv1, cp0, cp1;
  logic [A0-1:0] ax0, ay0;
  logic [A1-1:0] ax1, ay1;

  motion_delta_extractor #(.GRID_BITS(4), .ACC_SUM_BITS(A0), .EVENT_CNT_BITS(16),
    .HALF_WINDOW_CYCLES(H0), .MIN_EVENTS(4), .MIN_DELTA(8)) u0 (
    .clk(clk), .rst(rst), .ev_valid(ev_valid0), .ev_ready(ev_ready0),
    .ev_x(ev_x0), .ev_y(ev_y0), .class_gesture(gest0), .class_valid(cv0),
    .class_pass(cp0), .abs_delta_x(ax0), .abs_delta_y(ay0), .debug_state(dbg0));

  motion_delta_extractor #(.GRID_BITS(4), .ACC_SUM_BITS(A1), .EVENT_CNT_BITS(16),
    .HALF_WINDOW_CYCLES(H1), .MIN_EVENTS(4), .MIN_DELTA(8)) u1 (
    .clk(clk), .rst(rst), .ev_valid(ev_valid1), .ev_ready(ev_ready1),
    .ev_x(ev_x1), .ev_y(ev_y1), .class_gesture(gest1), .class_valid(cv1),
    .class_pass(cp1), .abs_delta_x(ax1), .abs_delta_y(ay1), .debug_state(dbg1));

  int n_checks = 0;
  int n_errors = 0;
  bit fin_req  = 1'b0;
  bit fin_done = 1'b0;

  // Model: the window is a position counter since reset release; sums are
  // plain integers clamped to the accumulator range after every event.
  int hh[2] = '{H0, H1};
  int aa[2] = '{A0, A1};
  int pos[2], sxe[2], sye[2], sxl[2], syl[2], cnt[2], win[2];
  int e_ax[2], e_ay[2], e_g[2], e_p[2];

  // Hand-computed per-window expectations {abs_x, abs_y, gesture, pass}.
  int lit0[6][4] = '{'{44, 0, 0, 1}, '{0, 36, 2, 1}, '{11, 0, 0, 0},
                     '{20, 20, 3, 1}, '{120, 0, 0, 1}, '{44, 0, 0, 1}};
  int lit1[4]    = '{127, 0, 1, 1};

  function automatic int clamp(input int v, input int a);
    int lo, hi;
    lo = -(1 <<< (a - 1));
    hi = (1 <<< (a - 1)) - 1;
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p, hk, r, cvv, dbg, g, cp, dax, day, v, x, y;
      r   = (k == 0) ? int'(ev_ready0) : int'(ev_ready1);
      cvv = (k == 0) ? int'(cv0) : int'(cv1);
      dbg = (k == 0) ? int'(dbg0) : int'(dbg1);
      g   = (k == 0) ? int'(gest0) : int'(gest1);
      cp  = (k == 0) ? int'(cp0) : int'(cp1);
      dax = (k == 0) ? int'(ax0) : int'(ax1);
      day = (k == 0) ? int'(ay0) : int'(ay1);
      v   = (k == 0) ? int'(ev_valid0) : int'(ev_valid1);
      x   = (k == 0) ? int'(ev_x0) : int'(ev_x1);
      y   = (k == 0) ? int'(ev_y0) : int'(ev_y1);
      if (rst) begin
        chk($sformatf("u%0d_ready_in_rst", k), r, 0);
        pos[k] = 0; sxe[k] = 0; sye[k] = 0; sxl[k] = 0; syl[k] = 0; cnt[k] = 0;
        e_ax[k] = 0; e_ay[k] = 0; e_g[k] = 0; e_p[k] = 0;
      end else begin
        p  = pos[k];
        hk = hh[k];
        chk($sformatf("u%0d_ev_ready", k), r, (p < 2*hk) ? 1 : 0);
        chk($sformatf("u%0d_debug_state", k), dbg, (p < hk) ? 0 : (p < 2*hk) ? 1 : (p == 2*hk) ? 2 : 3);
        chk($sformatf("u%0d_class_valid", k), cvv, (p == 2*hk + 1) ? 1 : 0);
        if (p == 2*hk + 1) begin
          int dx, dy, lo, hi, dom;
          lo = -(1 <<< (aa[k] - 1));
          hi = (1 <<< (aa[k] - 1)) - 1;
          dx = clamp(sxl[k] - sxe[k], aa[k]);
          dy = clamp(syl[k] - sye[k], aa[k]);
          e_ax[k] = (dx == lo) ? hi : iabs(dx);
          e_ay[k] = (dy == lo) ? hi : iabs(dy);
          if (e_ax[k] > e_ay[k]) begin
            e_g[k] = (dx > 0) ? 0 : 1;
            dom = e_ax[k];
          end else begin
            e_g[k] = (dy > 0) ? 3 : 2;
            dom = e_ay[k];
          end
          e_p[k] = (cnt[k] >= 4 && dom >= 8) ? 1 : 0;
          if (k == 0 && win[0] < 6) begin
            chk($sformatf("lit_w%0d_abs_x", win[0]), dax, lit0[win[0]][0]);
            chk($sformatf("lit_w%0d_abs_y", win[0]), day, lit0[win[0]][1]);
            chk($sformatf("lit_w%0d_gesture", win[0]), g, lit0[win[0]][2]);
            chk($sformatf("lit_w%0d_pass", win[0]), cp, lit0[win[0]][3]);
          end
          if (k == 1 && win[1] == 0) begin
            chk("lit_sat_abs_x", dax, lit1[0]);
            chk("lit_sat_abs_y", day, lit1[1]);
            chk("lit_sat_gesture", g, lit1[2]);
            chk("lit_sat_pass", cp, lit1[3]);
          end
          win[k]++;
        end
        chk($sformatf("u%0d_abs_x", k), dax, e_ax[k]);
        chk($sformatf("u%0d_abs_y", k), day, e_ay[k]);
        chk($sformatf("u%0d_gesture", k), g, e_g[k]);
        chk($sformatf("u%0d_pass", k), cp, e_p[k]);
        if (v != 0 && p < 2*hk) begin
          if (p < hk) begin
            sxe[k] = clamp(sxe[k] + x - 8, aa[k]);
            sye[k] = clamp(sye[k] + y - 8, aa[k]);
          end else begin
            sxl[k] = clamp(sxl[k] + x - 8, aa[k]);
            syl[k] = clamp(syl[k] + y - 8, aa[k]);
          end
          if (cnt[k] < 65535) cnt[k]++;
        end
        pos[k] = p + 1;
        if (pos[k] == 2*hk + 2) begin
          pos[k] = 0; sxe[k] = 0; sye[k] = 0; sxl[k] = 0; syl[k] = 0; cnt[k] = 0;
        end
      end
    end
    if (fin_req && !fin_done) begin
      fin_done = 1'b1;
      chk("u0_windows_emitted", win[0], 6);
      chk("u1_windows_emitted", win[1], 2);
    end
  end

  // One window on u0 starting at its first EARLY cycle. ne/nl events at the
  // start of each half; cont holds ev_valid high the whole window; abort_at
  // (>=0) pulses rst at that window position instead of finishing.
  task automatic window0(input int ne, input int xe, input int ye,
                         input int nl, input int xl, input int yl,
                         input int abort_at, input bit cont);
    for (int p = 0; p < 2*H0 + 2; p++) begin
      if (p == abort_at) begin
        ev_valid0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (cont) ev_valid0 = 1'b1;
      else ev_valid0 = (p < H0 && p < ne) || (p >= H0 && p < 2*H0 && (p - H0) < nl);
      ev_x0 = (p < H0) ? 4'(xe) : 4'(xl);
      ev_y0 = (p < H0) ? 4'(ye) : 4'(yl);
      @(posedge clk); #1;
    end
    ev_valid0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ev_valid0 = 1'b0; ev_x0 = 4'd8; ev_y0 = 4'd8;
    for (int k = 0; k < 2; k++) win[k] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    window0(4, 2, 8, 4, 13, 8, -1, 1'b0);   // RIGHT, +44
    window0(4, 8, 12, 4, 8, 3, -1, 1'b0);   // UP, -36
    window0(1, 2, 8, 1, 13, 8, -1, 1'b0);   // too few events
    window0(4, 8, 8, 4, 13, 13, -1, 1'b0);  // tie -> DOWN
    window0(0, 0, 8, 0, 15, 8, -1, 1'b1);   // ev_valid always high
    window0(4, 2, 8, 4, 13, 8, H0 + 3, 1'b0); // reset mid-LATE
    window0(4, 2, 8, 4, 13, 8, -1, 1'b0);   // clean window after reset
    repeat (3) @(posedge clk);
    #1 fin_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    if (!fin_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL final_window_count: got not-run expected run");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // u1: saturation window, 20 early events at x=15 then 20 late at x=0.
  initial begin
    ev_valid1 = 1'b0; ev_x1 = 4'd8; ev_y1 = 4'd8;
    wait (rst == 1'b0);
    for (int p = 0; p < 2*H1 + 2; p++) begin
      ev_valid1 = (p < 20) || (p >= H1 && p < H1 + 20);
      ev_x1 = (p < H1) ? 4'd15 : 4'd0;
      @(posedge clk); #1;
    end
    ev_valid1 = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
